// File: rtl/apb3_led_sequencer.sv
// APB3 LED bank driver: static value or a sequence of up to four patterns,
// each held for PRESCALE+1 cycles, run continuously or once with a done interrupt.
module apb3_led_sequencer #(
    parameter int ADDRWIDTH = 12
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 psel,
    input  logic [ADDRWIDTH-1:0] paddr,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [31:0]          led_out,
    output logic                 irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [2:0] R_CTRL     = 3'd0;
    localparam logic [2:0] R_STATIC   = 3'd1;
    localparam logic [2:0] R_PRESCALE = 3'd2;
    localparam logic [2:0] R_STATUS   = 3'd3;

    logic        ctrl_en, ctrl_mode, ctrl_oneshot, ctrl_ie;
    logic [1:0]  ctrl_last;
    logic [31:0] static_reg;
    logic [15:0] prescale;
    logic [31:0] pat [4];

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic        done;

    logic        mapped;
    logic [2:0]  reg_sel;
    logic        write_en;
    logic        ctrl_wr;

    // Any upper address bit set makes the access unmapped; paddr[1:0] is ignored.
    assign mapped   = ~|paddr[ADDRWIDTH-1:5];
    assign reg_sel  = paddr[4:2];
    assign write_en = psel & penable & pwrite & mapped;
    assign ctrl_wr  = write_en && (reg_sel == R_CTRL);

    assign pready  = 1'b1;
    assign pslverr = psel & penable & ~mapped;
    assign irq     = done & ctrl_ie;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl_en      <= 1'b0;
            ctrl_mode    <= 1'b0;
            ctrl_oneshot <= 1'b0;
            ctrl_ie      <= 1'b0;
            ctrl_last    <= 2'd0;
            static_reg   <= '0;
            prescale     <= '0;
            // NOTE: the pattern file is tiny and must read back 0 after reset, so it is reset like any register.
            for (int i = 0; i < 4; i++) pat[i] <= '0;
        end else if (write_en) begin
            case (reg_sel)
                R_CTRL: begin
                    ctrl_en      <= pwdata[0];
                    ctrl_mode    <= pwdata[1];
                    ctrl_oneshot <= pwdata[2];
                    ctrl_ie      <= pwdata[3];
                    ctrl_last    <= pwdata[5:4];
                end
                R_STATIC:   static_reg <= pwdata;
                R_PRESCALE: prescale   <= pwdata[15:0];
                R_STATUS:   ;
                default:    pat[reg_sel[1:0]] <= pwdata;
            endcase
        end
    end

    // Sequencer; a CTRL write takes priority over a step advance in the same cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            done    <= 1'b0;
            led_out <= '0;
        end else begin
            led_out <= (state == S_IDLE) ? static_reg : pat[idx];
            if (ctrl_wr) begin
                done  <= 1'b0;
                cnt   <= '0;
                idx   <= '0;
                state <= (pwdata[0] && pwdata[1]) ? S_RUN : S_IDLE;
            end else if (state == S_RUN) begin
                // >= (not ==) so a PRESCALE lowered below cnt ends the step next cycle.
                if (cnt >= prescale) begin
                    cnt <= '0;
                    if (idx != ctrl_last) begin
                        idx <= idx + 2'd1;
                    end else if (!ctrl_oneshot) begin
                        idx <= '0;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end

    // NOTE: prdata gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        prdata = '0;
        if (psel && mapped) begin
            case (reg_sel)
                R_CTRL:     prdata = {26'd0, ctrl_last, ctrl_ie, ctrl_oneshot, ctrl_mode, ctrl_en};
                R_STATIC:   prdata = static_reg;
                R_PRESCALE: prdata = {16'd0, prescale};
                R_STATUS:   prdata = {23'd0, done, 2'b00, idx, 3'b000, (state == S_RUN)};
                default:    prdata = pat[reg_sel[1:0]];
            endcase
        end
    end

endmodule

// File: tb/tb_apb3_led_sequencer.sv
// Directed bench for apb3_led_sequencer: register table plus hand-timed
// sequence, one-shot, prescale-change, restart, slverr and reset cases.
module tb_apb3_led_sequencer;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] led_out;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    apb3_led_sequencer #(.ADDRWIDTH(12)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .paddr   (paddr),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .led_out (led_out),
        .irq     (irq)
    );

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } reg_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        #1 err = pslverr;
        @(posedge pclk);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge pclk);
        penable = 1'b1;
        #1 begin d = prdata; err = pslverr; end
        @(posedge pclk);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reg_vec_t    vecs [9];
        logic [31:0] pats [4];
        logic [31:0] d;
        logic        e;

        pats[0] = 32'h1; pats[1] = 32'h2; pats[2] = 32'h4; pats[3] = 32'h8;
        vecs[0] = '{"ctrl_upper_only", 12'h000, 32'hFFFF_FFC0, 32'h0000_0000};
        vecs[1] = '{"static",          12'h004, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
        vecs[2] = '{"prescale",        12'h008, 32'hDEAD_0003, 32'h0000_0003};
        vecs[3] = '{"pat0",            12'h010, 32'h0000_0001, 32'h0000_0001};
        vecs[4] = '{"pat1",            12'h014, 32'h0000_0002, 32'h0000_0002};
        vecs[5] = '{"pat2",            12'h018, 32'h0000_0004, 32'h0000_0004};
        vecs[6] = '{"pat3",            12'h01C, 32'h0000_0008, 32'h0000_0008};
        vecs[7] = '{"status_ro",       12'h00C, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8] = '{"ctrl_static",     12'h000, 32'h0000_0000, 32'h0000_0000};

        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        presetn = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_led", led_out, 32'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_pready", pready, 1'b1);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_prdata", prdata, 32'h0);
        presetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apb_read(12'(i * 4), d, e);
            check($sformatf("rst_read_%0h", i * 4), d, 32'h0);
            check($sformatf("rst_err_%0h", i * 4), e, 1'b0);
        end

        for (int i = 0; i < 9; i++) begin
            apb_write(vecs[i].addr, vecs[i].wdata, e);
            check({vecs[i].name, "_werr"}, e, 1'b0);
            apb_read(vecs[i].addr, d, e);
            check({vecs[i].name, "_rd"}, d, vecs[i].rexp);
        end
        check("static_led", led_out, 32'hA5A5_0F0F);

        // STATIC write latency: unchanged right after the write edge, updated one edge later.
        apb_write(12'h004, 32'h1234_5678, e);
        check("static_lat_t0", led_out, 32'hA5A5_0F0F);
        @(negedge pclk);
        check("static_lat_t1", led_out, 32'h1234_5678);
        apb_write(12'h004, 32'hA5A5_0F0F, e);

        // Continuous sequence, PRESCALE=3: each pattern held 4 cycles.
        apb_write(12'h000, 32'h33, e);
        for (int i = 1; i <= 20; i++) begin
            @(negedge pclk);
            check($sformatf("cont_c%0d", i), led_out, pats[((i - 1) / 4) % 4]);
        end

        // One-shot with interrupt: done on the 16th edge after the start.
        apb_write(12'h000, 32'h3F, e);
        repeat (15) @(negedge pclk);
        check("os_irq_early", irq, 1'b0);
        check("os_led_c15", led_out, 32'h8);
        @(negedge pclk);
        check("os_irq_c16", irq, 1'b1);
        check("os_led_c16", led_out, 32'h8);
        apb_read(12'h00C, d, e);
        check("os_status", d, 32'h130);
        repeat (5) @(negedge pclk);
        check("os_led_hold", led_out, 32'h8);
        check("os_irq_hold", irq, 1'b1);
        apb_write(12'h000, 32'h0, e);
        check("os_irq_clr", irq, 1'b0);
        @(negedge pclk);
        check("os_led_static", led_out, 32'hA5A5_0F0F);

        // PRESCALE=0, LAST=1: alternate every cycle; a CTRL rewrite restarts at PAT0.
        apb_write(12'h008, 32'h0, e);
        apb_write(12'h000, 32'h13, e);
        for (int i = 1; i <= 5; i++) begin
            @(negedge pclk);
            check($sformatf("last1_c%0d", i), led_out, pats[(i - 1) % 2]);
        end
        apb_write(12'h000, 32'h33, e);
        for (int i = 1; i <= 3; i++) begin
            @(negedge pclk);
            check($sformatf("restart_c%0d", i), led_out, pats[i - 1]);
        end

        // PRESCALE lowered mid-step: advance on the next edge, then every 11 cycles.
        apb_write(12'h008, 32'd100, e);
        apb_write(12'h000, 32'h33, e);
        repeat (50) @(negedge pclk);
        check("ps_before", led_out, 32'h1);
        apb_write(12'h008, 32'd10, e);
        check("ps_w0", led_out, 32'h1);
        @(negedge pclk);
        check("ps_w1", led_out, 32'h1);
        @(negedge pclk);
        check("ps_w2_adv", led_out, 32'h2);
        repeat (10) @(negedge pclk);
        check("ps_w12_hold", led_out, 32'h2);
        @(negedge pclk);
        check("ps_w13_adv", led_out, 32'h4);
        apb_read(12'h00C, d, e);
        check("ps_status", d, 32'h21);

        // Unmapped accesses: error response, no register change, read data 0.
        apb_write(12'h024, 32'hFFFF_FFFF, e);
        check("unm_w24_err", e, 1'b1);
        apb_write(12'h104, 32'hDEAD_BEEF, e);
        check("unm_w104_err", e, 1'b1);
        apb_read(12'h040, d, e);
        check("unm_r40_err", e, 1'b1);
        check("unm_r40_data", d, 32'h0);
        apb_read(12'h004, d, e);
        check("unm_static_kept", d, 32'hA5A5_0F0F);
        check("unm_static_err", e, 1'b0);
        apb_read(12'h008, d, e);
        check("unm_prescale_kept", d, 32'd10);
        check("idle_pslverr", pslverr, 1'b0);

        // Asynchronous reset mid-sequence clears led_out without a clock edge.
        apb_write(12'h000, 32'h3B, e);
        repeat (3) @(negedge pclk);
        check("arst_pre_led", led_out, 32'h1);
        #2 presetn = 1'b0;
        #1 check("arst_led", led_out, 32'h0);
        check("arst_irq", irq, 1'b0);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        check("arst_led_after", led_out, 32'h0);
        apb_read(12'h000, d, e);
        check("arst_ctrl", d, 32'h0);
        apb_read(12'h00C, d, e);
        check("arst_status", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb3_led_sequencer.md
# apb3_led_sequencer

- APB3 slave that drives the board LED bank.
- Outputs either a static value or a programmable sequence of up to four 32-bit patterns.
- Each pattern is held for a programmable dwell time. Sequences run continuously or once.
- Sits on the APB peripheral bus in place of a bare LED write register. Adds readback, a status register and a done interrupt.

## Interface
Parameters:
- ADDRWIDTH, 12: APB address width; only paddr[4:2] is decoded, and upper bits must be zero for a mapped access.

Ports:
- pclk  in  1  clock
- presetn  in  1  reset, asynchronous, active-low
- psel  in  1  APB select
- paddr  in  ADDRWIDTH  APB byte address
- penable  in  1  APB access phase
- pwrite  in  1  1 = write
- pwdata  in  32  write data
- prdata  out  32  read data, valid in access phase
- pready  out  1  tied 1, no wait states
- pslverr  out  1  error response for unmapped address
- led_out  out  32  LED drive, registered
- irq  out  1  sequence-done interrupt, level

## Operation
Register map (byte offsets):
- 0x00 CTRL, RW
  - [0] EN
  - [1] MODE (0 static, 1 sequence)
  - [2] ONESHOT
  - [3] IE
  - [5:4] LAST (index of final step)
  - Other bits read 0.
- 0x04 STATIC, RW, 32 bits.
- 0x08 PRESCALE, RW, [15:0]; upper bits read 0.
- 0x0C STATUS, RO
  - [0] BUSY
  - [5:4] IDX (current step)
  - [8] DONE
  - Writes are ignored without error.
- 0x10, 0x14, 0x18, 0x1C: PAT0 to PAT3, RW.

APB behaviour:
- write_en = psel & penable & pwrite. Registers update on the pclk edge that ends the access phase.
- Reads are combinational from paddr and return register contents.
- An unmapped offset (0x20 and above, or any upper address bit set) gives pslverr = psel & penable.
  - The write is dropped and prdata reads 0.
- pslverr is 0 whenever psel is 0.

Sequencer FSM, with states IDLE, RUN and DONE:
- IDLE: entered on reset and on any CTRL write with EN=0 or MODE=0. cnt=0, idx=0, BUSY=0.
- RUN: entered on any CTRL write with EN=1 and MODE=1, including a write while already in RUN or DONE (restart).
  - On entry: idx=0, cnt=0, DONE=0, BUSY=1.
  - Each cycle, if cnt >= PRESCALE then cnt←0 and the step advances; otherwise cnt←cnt+1.
  - Advance rules:
    - If idx != LAST: idx←idx+1.
    - If idx == LAST and ONESHOT=0: idx←0 (wrap).
    - If idx == LAST and ONESHOT=1: go to DONE. DONE←1, BUSY←0, idx stays at LAST.
- DONE: holds PAT[LAST] until the next CTRL write.

Other rules:
- Any CTRL write clears DONE.
- led_out is registered each cycle: STATIC if state is IDLE, else PAT[idx].
- irq = DONE & IE, where IE is the current CTRL value.
- PRESCALE written mid-run takes effect immediately. The >= compare guarantees the current step ends on the next cycle if cnt already exceeds the new value; the counter never wraps through 0xFFFF.
- LAST reduced below idx mid-run (CTRL write) is covered by the restart to idx=0.
- PAT or STATIC writes mid-run appear on led_out one cycle after the write edge.

## Timing
- Reset values:
  - led_out=0, irq=0, prdata=0, pslverr=0, pready=1.
  - All registers 0. FSM in IDLE.
- Write latency: a register is written at edge T. led_out reflects it at edge T+1.
- Sequence timing:
  - Start by CTRL write at edge T. PAT0 appears on led_out at T+1.
  - Each step is visible for exactly PRESCALE+1 cycles.
  - PRESCALE=0 advances every cycle.
- One-shot completion: DONE, and irq if IE=1, assert on the same edge that the final step's dwell ends. led_out keeps PAT[LAST].
- A CTRL write in the same cycle as a step advance: the write wins (restart or IDLE).
- Reset asserted mid-sequence: all state clears asynchronously and led_out goes to 0 immediately.

## Test plan
- Reset, then read all offsets → prdata 0 for every register, led_out=0, pslverr=0.
- Write STATIC=0xA5A5_0F0F, then CTRL=0x0 → led_out=0xA5A5_0F0F one cycle after the write edge; readback matches.
- Set PAT0..3=0x1,0x2,0x4,0x8, PRESCALE=3, then write CTRL=0x33 (EN, MODE, LAST=3, continuous) → led_out shows 1,2,4,8,1,... with each value held exactly 4 cycles; STATUS.IDX tracks the step.
- Same setup with CTRL=0x3F (ONESHOT, IE) → after 16 cycles led_out holds 0x8, STATUS reads 0x130 (DONE=1, IDX=3, BUSY=0) and irq=1. A subsequent CTRL=0x0 write → irq=0 and led_out returns to STATIC.
- While running with PRESCALE=100 and cnt at roughly 50, write PRESCALE=10 → the step advances on the next cycle, then every 11 cycles.
- Write to 0x24 and read 0x40 → pslverr=1 in the access phase of both; no register changes; prdata=0.
